// File: rtl/pcs_pkg.sv
`default_nettype none
//==============================================================================
// Module : pcs_pkg
// Desc   : PCS control characters and framer state encoding shared by TX/RX.
// Rev    : 1.0  initial release
//==============================================================================
package pcs_pkg;

  localparam logic [7:0] K_IDLE = 8'hBC;  // K28.5, also used as alignment comma
  localparam logic [7:0] K_SOF  = 8'h3C;  // K28.1
  localparam logic [7:0] K_EOF  = 8'hDC;  // K28.6

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_DATA = 3'd2,
    ST_EOF  = 3'd3,
    ST_GAP  = 3'd4
  } framer_state_e;

endpackage
`default_nettype wire

// File: rtl/pcs_tx_framer.sv
`default_nettype none
//==============================================================================
// Module : pcs_tx_framer
// Desc   : Frames a valid/ready byte stream into SOF/data/EOF symbols for the
//          8b/10b encoder, with K28.5 idle fill, alignment and inter-frame gap.
// Rev    : 1.0  initial release
//==============================================================================
module pcs_tx_framer
  import pcs_pkg::*;
#(
  parameter int unsigned IDLE_GAP       = 2,
  parameter int unsigned ALIGN_INTERVAL = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             link_en,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic             enc_en,
  output logic [7:0]       enc_data,
  output logic             enc_k,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] underrun_cnt
);

  localparam logic [7:0] c_align_max = 8'(ALIGN_INTERVAL);
  localparam logic [3:0] c_gap_last  = 4'(IDLE_GAP - 1);

  framer_state_e r_state;
  framer_state_e w_state_nxt;
  logic [7:0]    r_run_cnt;
  logic [7:0]    w_run_nxt;
  logic [3:0]    r_gap_cnt;
  logic [3:0]    w_gap_nxt;
  logic [7:0]    w_sym_data;
  logic          w_sym_k;
  logic          w_frame_inc;
  logic          w_underrun_inc;

  // Ready depends only on state so upstream sees it before presenting data.
  assign s_ready = (r_state == ST_DATA) && (r_run_cnt != c_align_max);
  assign busy    = (r_state != ST_IDLE);

  always_comb begin
    w_state_nxt    = r_state;
    w_run_nxt      = r_run_cnt;
    w_gap_nxt      = r_gap_cnt;
    w_sym_data     = K_IDLE;
    w_sym_k        = 1'b1;
    w_frame_inc    = 1'b0;
    w_underrun_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (link_en && s_valid) begin
          w_state_nxt = ST_SOF;
        end
      end
      ST_SOF: begin
        w_sym_data  = K_SOF;
        w_run_nxt   = 8'd0;
        w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (r_run_cnt == c_align_max) begin
          w_run_nxt = 8'd0;
        end else if (s_valid) begin
          w_sym_data = s_data;
          w_sym_k    = 1'b0;
          if (s_last) begin
            w_state_nxt = ST_EOF;
          end else begin
            w_run_nxt = r_run_cnt + 8'd1;
          end
        end else begin
          // Upstream starved mid-frame: pad with a comma and restart the run.
          w_run_nxt      = 8'd0;
          w_underrun_inc = 1'b1;
        end
      end
      ST_EOF: begin
        w_sym_data  = K_EOF;
        w_frame_inc = 1'b1;
        w_gap_nxt   = 4'd0;
        w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        w_gap_nxt = r_gap_cnt + 4'd1;
        if (r_gap_cnt == c_gap_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_run_cnt    <= 8'd0;
      r_gap_cnt    <= 4'd0;
      enc_en       <= 1'b0;
      enc_data     <= K_IDLE;
      enc_k        <= 1'b1;
      frame_cnt    <= '0;
      underrun_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_run_cnt <= w_run_nxt;
      r_gap_cnt <= w_gap_nxt;
      enc_en    <= 1'b1;
      enc_data  <= w_sym_data;
      enc_k     <= w_sym_k;
      if (w_frame_inc) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (w_underrun_inc) begin
        underrun_cnt <= underrun_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/pcs_tx_framer.md
Name: pcs_tx_framer

Overview:
- Byte-stream framer sitting directly upstream of the 8b/10b encoder in the PCS TX path.
- Accepts frames over a valid/ready byte interface and emits one (byte, K-flag) symbol per clock to the encoder.
- Wraps each frame with SOF/EOF control characters and fills idle time with K28.5 commas.
- Inserts periodic K28.5 alignment commas inside long frames and enforces a minimum inter-frame gap.

Parameters:
- IDLE_GAP, 2: minimum K28.5 idles between EOF and next SOF (1..15).
- ALIGN_INTERVAL, 64: maximum consecutive data bytes before a forced in-frame K28.5 (2..255).
- CNT_W, 16: width of frame and underrun counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- link_en  in  1  permits new frames to start; sampled only in IDLE.
- s_valid  in  1  upstream byte valid.
- s_data  in  8  upstream byte.
- s_last  in  1  marks the final byte of a frame.
- s_ready  out  1  byte accepted when s_valid && s_ready at posedge; combinational from state/counters.
- enc_en  out  1  drives encoder tx_en.
- enc_data  out  8  symbol byte to encoder data_in.
- enc_k  out  1  drives encoder k_select.
- busy  out  1  state != IDLE.
- frame_cnt  out  CNT_W  completed frames (EOF emitted); wraps.
- underrun_cnt  out  CNT_W  in-frame filler insertions; wraps.

Behaviour:
- Constants:
  - IDLE/ALIGN = K28.5 (8'hBC, k=1).
  - SOF = K28.1 (8'h3C, k=1).
  - EOF = K28.6 (8'hDC, k=1).
  - Only K28.x symbols are ever emitted with k=1.
- Reset values:
  - enc_data=8'hBC, enc_k=1, enc_en=0.
  - frame_cnt=0, underrun_cnt=0, run_cnt=0, gap_cnt=0.
  - state=IDLE.
- enc_en rises to 1 on the first clock after reset release and stays 1.
- All enc_* outputs are registered. A byte accepted at edge N appears on enc_data after edge N.
- States: IDLE, SOF, DATA, EOF, GAP.
- IDLE:
  - Emit K28.5; s_ready=0.
  - If link_en && s_valid, go to SOF. The byte is not consumed.
- SOF:
  - Emit SOF; run_cnt=0; s_ready=0; go to DATA.
- DATA:
  - s_ready = (run_cnt != ALIGN_INTERVAL).
  - Accept with s_last=0: emit s_data with k=0; run_cnt++.
  - Accept with s_last=1: emit s_data with k=0; go to EOF.
  - run_cnt == ALIGN_INTERVAL: emit K28.5; run_cnt=0; s_ready=0 this cycle.
  - s_valid=0 while s_ready=1 (underrun): emit K28.5 filler; run_cnt=0; underrun_cnt++.
- EOF:
  - Emit EOF; frame_cnt++; gap_cnt=0; s_ready=0; go to GAP.
- GAP:
  - Emit K28.5; gap_cnt++.
  - Go to IDLE once IDLE_GAP idles have been emitted, i.e. gap_cnt reaches IDLE_GAP-1 at that edge.
- link_en:
  - Deassertion mid-frame has no effect; the frame completes normally.
  - Deassertion in IDLE holds IDLE indefinitely.
- Data byte 8'hBC with k=0 is legal payload and passes untouched.
- Single-byte frame (s_last on first byte) yields SOF, D, EOF.
- Counters wrap at 2^CNT_W with no saturation.
- Asynchronous reset mid-frame:
  - Immediately returns all outputs to reset values.
  - The partial frame is dropped, with no EOF.
  - Upstream is responsible for discarding its remainder.

Decomposition:
- Shared package pcs_pkg:
  - K_IDLE=8'hBC, K_SOF=8'h3C, K_EOF=8'hDC.
  - Framer state enum.
  - Reused by the RX deframer.
- No sub-module. Counters and FSM are inline, roughly 150–200 lines.

Test Plan:
- Reset then idle: hold rst_n low, release with s_valid=0.
  - During reset: enc_data=BC, enc_k=1, enc_en=0.
  - From the 1st post-reset clock: enc_en=1 and continuous BC/k=1.
- 3-byte frame 11,22,33 (s_last on 33), link_en=1, s_valid held:
  - Output sequence: BC/k, 3C/k, 11, 22, 33, DC/k, BC/k, BC/k, then next frame allowed.
  - frame_cnt=1.
- ALIGN_INTERVAL=4, 10-byte frame 00..09:
  - Data runs are 00–03, BC/k, 04–07, BC/k, 08–09, DC/k.
  - s_ready low exactly on the two BC cycles.
- Underrun: drop s_valid for 2 cycles after byte 2 of a frame.
  - Two BC/k fillers mid-frame, then remaining bytes.
  - underrun_cnt=2; frame intact.
- Back-to-back frames with s_valid always high, IDLE_GAP=2:
  - Between frames: DC/k, exactly 2 BC/k in GAP, 1 BC/k in IDLE, then 3C/k.
- link_en and reset cases:
  - link_en dropped mid-frame: frame completes with EOF.
  - link_en=0 in IDLE with s_valid=1: stays BC forever, s_ready=0.
  - rst_n pulsed during DATA: outputs return to BC/k, enc_en=0; no EOF emitted.
